button_reader: RTL and testbench

BUTTON_READER -- requirements
Module: button_reader

---
 rtl/button_reader_if.sv | 26 ++
 rtl/button_reader.sv | 159 +++++++++++++++
 tb/tb_button_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/button_reader_if.sv
// Button reader bus: raw active-low pins in, debounced level and event pulses out.
interface button_reader_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_n_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] long_o;

  modport master (
    output btn_n_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  long_o
  );

  modport slave (
    input  btn_n_i,
    output level_o,
    output press_o,
    output release_o,
    output long_o
  );
endinterface

// File: rtl/button_reader.sv
// Multi-channel push-button reader: synchronize, debounce, and report
// press / release / long-press events per channel with registered outputs.
//
// state        | meaning
// IDLE         | button released, waiting for a pressed sample
// PRESS_WAIT   | qualifying a press; any released sample aborts to IDLE
// PRESSED      | press qualified, long-press timer running
// LONG_HELD    | long press reported, timer frozen until release
// RELEASE_WAIT | qualifying a release; a pressed sample returns to origin
module button_reader #(
  parameter int N_BTN             = 2,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000
) (
  input logic           clk,
  input logic           rst,
  button_reader_if.slave bus
);

  localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $fatal(1, "button_reader: need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          btn_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_flag_q, long_flag_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    assign btn_s = ~sync2_q;

    // Two-flop synchronizer; reset value 1 reads as "released".
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= bus.btn_n_i[i];
        sync2_q <= sync1_q;
      end
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        long_flag_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        long_flag_q <= long_flag_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
      end
    end

    // Next-state, timer and event decode; pulses default low every cycle.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_flag_d = long_flag_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_TC) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == LONG_TC) begin
            state_d     = LONG_HELD;
            long_d      = 1'b1;
            long_flag_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LONG_HELD: begin
          if (!btn_s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            // A glitch back to pressed resumes where we came from; the
            // long-press timer restarts only when returning to PRESSED.
            state_d = long_flag_q ? LONG_HELD : PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_TC) begin
            state_d     = IDLE;
            cnt_d       = '0;
            release_d   = 1'b1;
            level_d     = 1'b0;
            long_flag_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          long_flag_d = 1'b0;
          level_d     = 1'b0;
        end
      endcase
    end

    assign bus.level_o[i]   = level_q;
    assign bus.press_o[i]   = press_q;
    assign bus.release_o[i] = release_q;
    assign bus.long_o[i]    = long_q;
  end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed event edges.
module tb_button_reader;
  localparam int NB = 2;
  localparam int D  = 4;
  localparam int L  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  button_reader_if #(.N_BTN(NB)) bus ();

  button_reader #(
    .N_BTN(NB),
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  // Reference model: pins delayed two edges, then qualified by run length.
  bit md1[NB] = '{1'b1, 1'b1};
  bit md2[NB] = '{1'b1, 1'b1};
  int run1[NB], run0[NB], tl[NB];
  bit mlvl[NB], fired[NB];
  logic [NB-1:0] e_level, e_press, e_rel, e_long;

  // DUT event bookkeeping for directed checks.
  int press_cnt[NB], rel_cnt[NB], long_cnt[NB];
  int press_edge[NB], rel_edge[NB], long_edge[NB];
  int both_seen = 0;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Advance the model at each edge, then compare the registered outputs.
  always @(posedge clk) begin
    logic [NB-1:0] raw;
    bit rv, s;
    edge_n++;
    raw = bus.btn_n_i;
    rv  = rst;
    for (int c = 0; c < NB; c++) begin
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_long[c]  = 1'b0;
      if (!rv) begin
        md1[c] = 1'b1; md2[c] = 1'b1;
        run1[c] = 0; run0[c] = 0; tl[c] = 0;
        mlvl[c] = 1'b0; fired[c] = 1'b0;
      end else begin
        s = !md2[c];
        md2[c] = md1[c];
        md1[c] = raw[c];
        if (s) begin run1[c]++; run0[c] = 0; end
        else begin run0[c]++; run1[c] = 0; end
        if (!mlvl[c]) begin
          if (s && run1[c] == D + 1) begin
            e_press[c] = 1'b1; mlvl[c] = 1'b1; tl[c] = 0; fired[c] = 1'b0;
          end
        end else if (s) begin
          if (run1[c] == 1) tl[c] = 0;
          else tl[c]++;
          if (!fired[c] && tl[c] == L) begin
            e_long[c] = 1'b1; fired[c] = 1'b1;
          end
        end else if (run0[c] == D + 1) begin
          e_rel[c] = 1'b1; mlvl[c] = 1'b0;
        end
      end
      e_level[c] = mlvl[c];
    end
    #1;
    check("level_o", bus.level_o, e_level);
    check("press_o", bus.press_o, e_press);
    check("release_o", bus.release_o, e_rel);
    check("long_o", bus.long_o, e_long);
    for (int c = 0; c < NB; c++) begin
      if (bus.press_o[c] === 1'b1)   begin press_cnt[c]++; press_edge[c] = edge_n; end
      if (bus.release_o[c] === 1'b1) begin rel_cnt[c]++;   rel_edge[c]   = edge_n; end
      if (bus.long_o[c] === 1'b1)    begin long_cnt[c]++;  long_edge[c]  = edge_n; end
    end
    if (bus.press_o === 2'b11) both_seen++;
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e, g, r, p0, r0, l0, p1, r1, l1, b0;
    bus.btn_n_i = 2'b11;
    rst = 1'b0;
    nclk(3);
    check("reset_outputs", bus.level_o | bus.press_o | bus.release_o | bus.long_o, 2'b00);
    rst = 1'b1;
    nclk(3);

    // Clean press held 8 cycles, then release.
    p0 = press_cnt[0]; r0 = rel_cnt[0]; l0 = long_cnt[0];
    bus.btn_n_i[0] = 1'b0; e = edge_n;
    nclk(8);
    bus.btn_n_i[0] = 1'b1; r = edge_n;
    nclk(12);
    check_int("clean_press_edge", press_edge[0] - e, 7);
    check_int("clean_release_edge", rel_edge[0] - r, 7);
    check_int("clean_counts", (press_cnt[0]-p0)*100 + (rel_cnt[0]-r0)*10 + (long_cnt[0]-l0), 110);

    // Bounce: low 2, high 1, then low held.
    p0 = press_cnt[0];
    bus.btn_n_i[0] = 1'b0; nclk(2);
    bus.btn_n_i[0] = 1'b1; nclk(1);
    bus.btn_n_i[0] = 1'b0; e = edge_n;
    nclk(12);
    check_int("bounce_press_edge", press_edge[0] - e, 7);
    check_int("bounce_press_count", press_cnt[0] - p0, 1);
    bus.btn_n_i[0] = 1'b1; nclk(12);

    // Long press on channel 1: held 30 cycles.
    p1 = press_cnt[1]; r1 = rel_cnt[1]; l1 = long_cnt[1];
    bus.btn_n_i[1] = 1'b0; e = edge_n;
    nclk(30);
    bus.btn_n_i[1] = 1'b1; r = edge_n;
    nclk(12);
    check_int("long_press_edge", press_edge[1] - e, 7);
    check_int("long_long_edge", long_edge[1] - press_edge[1], 10);
    check_int("long_release_edge", rel_edge[1] - r, 7);
    check_int("long_counts", (press_cnt[1]-p1)*100 + (long_cnt[1]-l1)*10 + (rel_cnt[1]-r1), 111);

    // Release glitch while LONG_HELD.
    p0 = press_cnt[0]; r0 = rel_cnt[0]; l0 = long_cnt[0];
    bus.btn_n_i[0] = 1'b0; nclk(20);
    bus.btn_n_i[0] = 1'b1; nclk(2);
    bus.btn_n_i[0] = 1'b0; nclk(8);
    check("glitch_level_held", bus.level_o, 2'b01);
    check_int("glitch_no_release", rel_cnt[0] - r0, 0);
    nclk(12);
    bus.btn_n_i[0] = 1'b1; nclk(12);
    check_int("glitch_counts", (press_cnt[0]-p0)*100 + (long_cnt[0]-l0)*10 + (rel_cnt[0]-r0), 111);

    // Release glitch while PRESSED restarts the long-press timer.
    bus.btn_n_i[0] = 1'b0; e = edge_n; nclk(8);
    bus.btn_n_i[0] = 1'b1; nclk(2);
    bus.btn_n_i[0] = 1'b0; nclk(20);
    check_int("restart_long_edge", long_edge[0] - e, 23);
    bus.btn_n_i[0] = 1'b1; nclk(12);

    // Both channels pressed on the same edge.
    b0 = both_seen;
    bus.btn_n_i = 2'b00; e = edge_n;
    nclk(10);
    check_int("both_press_same_cycle", both_seen - b0, 1);
    check_int("both_press_edge1", press_edge[1] - e, 7);
    bus.btn_n_i = 2'b11; nclk(12);

    // Reset mid-press, then release reset with the button still held.
    r0 = rel_cnt[0];
    bus.btn_n_i[0] = 1'b0; nclk(10);
    check("pre_reset_level", bus.level_o, 2'b01);
    rst = 1'b0; nclk(3);
    check("reset_mid_press", bus.level_o | bus.press_o | bus.release_o | bus.long_o, 2'b00);
    check_int("reset_no_release", rel_cnt[0] - r0, 0);
    rst = 1'b1; e = edge_n;
    nclk(10);
    check_int("post_reset_press_edge", press_edge[0] - e, 7);
    bus.btn_n_i[0] = 1'b1; nclk(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
